// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, special register IDs and status codes.
package y86_pkg;

   localparam logic [3:0] I_HALT  = 4'h0;
   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_CMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [3:0] R_RSP  = 4'h4;
   localparam logic [3:0] R_NONE = 4'hF;

   typedef enum logic [1:0] {
      S_AOK = 2'd0,
      S_HLT = 2'd1,
      S_ADR = 2'd2,
      S_INS = 2'd3
   } stat_e;

endpackage

// File: rtl/wb_dst_sel.sv
// Combinational write-back destination selector; shared with the pipeline hazard logic.
module wb_dst_sel
   import y86_pkg::*;
(
   input  logic [3:0] icode,
   input  logic [3:0] rA,
   input  logic [3:0] rB,
   input  logic       cnd,
   output logic [3:0] dstE,
   output logic [3:0] dstM
);

   always_comb begin
      dstE = R_NONE;
      case (icode)
         I_CMOV:                        dstE = cnd ? rB : R_NONE;
         I_IRMOV, I_OPQ:                dstE = rB;
         I_PUSH, I_POP, I_CALL, I_RET:  dstE = R_RSP;
         default:                       dstE = R_NONE;
      endcase
   end

   always_comb begin
      dstM = R_NONE;
      case (icode)
         I_MRMOV, I_POP: dstM = rA;
         default:        dstM = R_NONE;
      endcase
   end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 SEQ write-back stage: architectural register file, E/M commit ports and sticky halt.
module writeback_regfile
   import y86_pkg::*;
#(
   parameter int unsigned     REG_W    = 64,
   parameter int unsigned     NREGS    = 15,
   parameter logic [REG_W-1:0] RSP_INIT = 64'h0000_0000_0000_0200
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wb_en,
   input  logic [3:0]       icode,
   input  logic [3:0]       rA,
   input  logic [3:0]       rB,
   input  logic             cnd,
   input  logic [REG_W-1:0] valE,
   input  logic [REG_W-1:0] valM,
   input  logic [1:0]       stat,
   output logic [REG_W-1:0] reg0,
   output logic [REG_W-1:0] reg1,
   output logic [REG_W-1:0] reg2,
   output logic [REG_W-1:0] reg3,
   output logic [REG_W-1:0] reg4,
   output logic [REG_W-1:0] reg5,
   output logic [REG_W-1:0] reg6,
   output logic [REG_W-1:0] reg7,
   output logic [REG_W-1:0] reg8,
   output logic [REG_W-1:0] reg9,
   output logic [REG_W-1:0] reg10,
   output logic [REG_W-1:0] reg11,
   output logic [REG_W-1:0] reg12,
   output logic [REG_W-1:0] reg13,
   output logic [REG_W-1:0] reg14,
   output logic [3:0]       dstE,
   output logic [3:0]       dstM,
   output logic             halted
);

   logic [REG_W-1:0] r_regs [NREGS];
   logic             r_halted;
   logic [3:0]       w_dst_e;
   logic [3:0]       w_dst_m;
   logic             w_retire;

   wb_dst_sel u_dst_sel (
      .icode (icode),
      .rA    (rA),
      .rB    (rB),
      .cnd   (cnd),
      .dstE  (w_dst_e),
      .dstM  (w_dst_m)
   );

   assign w_retire = wb_en & ~r_halted;

   // Index compare per register: ID 0xF matches nothing, so it can never alias a real register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= (4'(i) == R_RSP) ? RSP_INIT : '0;
         end
         r_halted <= 1'b0;
      end else if (w_retire) begin
         if (stat != S_AOK) begin
            r_halted <= 1'b1;
         end else begin
            for (int i = 0; i < NREGS; i++) begin
               if (w_dst_m == 4'(i)) begin
                  r_regs[i] <= valM;
               end else if (w_dst_e == 4'(i)) begin
                  r_regs[i] <= valE;
               end
            end
         end
      end
   end

   assign dstE   = w_dst_e;
   assign dstM   = w_dst_m;
   assign halted = r_halted;

   assign reg0  = r_regs[0];
   assign reg1  = r_regs[1];
   assign reg2  = r_regs[2];
   assign reg3  = r_regs[3];
   assign reg4  = r_regs[4];
   assign reg5  = r_regs[5];
   assign reg6  = r_regs[6];
   assign reg7  = r_regs[7];
   assign reg8  = r_regs[8];
   assign reg9  = r_regs[9];
   assign reg10 = r_regs[10];
   assign reg11 = r_regs[11];
   assign reg12 = r_regs[12];
   assign reg13 = r_regs[13];
   assign reg14 = r_regs[14];

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: a behavioural model checked every cycle plus literal pins.
module tb_writeback_regfile;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_en;
   logic [3:0]  icode;
   logic [3:0]  rA;
   logic [3:0]  rB;
   logic        cnd;
   logic [63:0] valE;
   logic [63:0] valM;
   logic [1:0]  stat;
   logic [63:0] d_regs [15];
   logic [3:0]  dstE;
   logic [3:0]  dstM;
   logic        halted;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   logic [63:0] m_regs [15];
   logic        m_halted;

   always #5 clk = ~clk;

   writeback_regfile dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .wb_en  (wb_en),
      .icode  (icode),
      .rA     (rA),
      .rB     (rB),
      .cnd    (cnd),
      .valE   (valE),
      .valM   (valM),
      .stat   (stat),
      .reg0   (d_regs[0]),
      .reg1   (d_regs[1]),
      .reg2   (d_regs[2]),
      .reg3   (d_regs[3]),
      .reg4   (d_regs[4]),
      .reg5   (d_regs[5]),
      .reg6   (d_regs[6]),
      .reg7   (d_regs[7]),
      .reg8   (d_regs[8]),
      .reg9   (d_regs[9]),
      .reg10  (d_regs[10]),
      .reg11  (d_regs[11]),
      .reg12  (d_regs[12]),
      .reg13  (d_regs[13]),
      .reg14  (d_regs[14]),
      .dstE   (dstE),
      .dstM   (dstM),
      .halted (halted)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_dst_e(input int ic, input int rb, input bit c);
      if (ic == 2) return c ? rb : 15;
      if (ic == 3 || ic == 6) return rb;
      if (ic == 8 || ic == 9 || ic == 10 || ic == 11) return 4;
      return 15;
   endfunction

   function automatic int exp_dst_m(input int ic, input int ra);
      if (ic == 5 || ic == 11) return ra;
      return 15;
   endfunction

   // Every cycle: architectural state and combinational destinations against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < 15; i++) check($sformatf("reg%0d", i), d_regs[i], m_regs[i]);
         check("halted", 64'(halted), 64'(m_halted));
         check("dstE", 64'(dstE), 64'(exp_dst_e(int'(icode), int'(rB), cnd)));
         check("dstM", 64'(dstM), 64'(exp_dst_m(int'(icode), int'(rA))));
      end
   end

   task automatic drive(input bit rst, input bit en, input logic [3:0] ic, input logic [3:0] ra,
                        input logic [3:0] rb, input bit c, input logic [63:0] ve,
                        input logic [63:0] vm, input logic [1:0] st);
      rst_n = rst; wb_en = en; icode = ic; rA = ra; rB = rb; cnd = c;
      valE = ve; valM = vm; stat = st;
   endtask

   task automatic tick();
      int de;
      int dm;
      @(posedge clk);
      de = exp_dst_e(int'(icode), int'(rB), cnd);
      dm = exp_dst_m(int'(icode), int'(rA));
      if (!rst_n) begin
         for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? 64'h200 : 64'h0;
         m_halted = 1'b0;
      end else if (wb_en && !m_halted) begin
         if (stat != 2'd0) begin
            m_halted = 1'b1;
         end else begin
            if (de != 15) m_regs[de] = valE;
            if (dm != 15) m_regs[dm] = valM;
         end
      end
      #1;
   endtask

   task automatic apply(input bit rst, input bit en, input logic [3:0] ic, input logic [3:0] ra,
                        input logic [3:0] rb, input bit c, input logic [63:0] ve,
                        input logic [63:0] vm, input logic [1:0] st);
      drive(rst, en, ic, ra, rb, c, ve, vm, st);
      tick();
   endtask

   initial begin
      drive(1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 2'd0);
      tick();
      tick();
      cmp_en = 1'b1;
      drive(1'b1, 1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 2'd0);
      #1;
      check("reset_reg4", d_regs[4], 64'h200);
      check("reset_reg0", d_regs[0], 64'h0);
      check("reset_halted", 64'(halted), 64'h0);
      check("nop_dstE", 64'(dstE), 64'hF);
      check("nop_dstM", 64'(dstM), 64'hF);
      tick();

      apply(1'b1, 1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 2'd0);
      check("irmovq_reg2", d_regs[2], 64'h1234);
      check("irmovq_reg3", d_regs[3], 64'h0);
      apply(1'b1, 1'b1, 4'h6, 4'hF, 4'h2, 1'b0, 64'h55, 64'h0, 2'd0);
      check("opq_reg2", d_regs[2], 64'h55);

      drive(1'b1, 1'b1, 4'h2, 4'hF, 4'h3, 1'b0, 64'h7, 64'h0, 2'd0);
      #1;
      check("cmov_nc_dstE", 64'(dstE), 64'hF);
      tick();
      check("cmov_nc_reg3", d_regs[3], 64'h0);
      apply(1'b1, 1'b1, 4'h2, 4'hF, 4'h3, 1'b1, 64'h7, 64'h0, 2'd0);
      check("cmov_c_reg3", d_regs[3], 64'h7);

      drive(1'b1, 1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h208, 64'hABCD, 2'd0);
      #1;
      check("popq_dstE", 64'(dstE), 64'h4);
      check("popq_dstM", 64'(dstM), 64'h4);
      tick();
      check("popq_rsp_reg4", d_regs[4], 64'hABCD);
      apply(1'b1, 1'b1, 4'hB, 4'h3, 4'hF, 1'b0, 64'h208, 64'hABCD, 2'd0);
      check("popq_rbx_reg3", d_regs[3], 64'hABCD);
      check("popq_rbx_reg4", d_regs[4], 64'h208);

      // Remaining decodes, full-width data and a 0xF specifier.
      apply(1'b1, 1'b1, 4'h5, 4'hE, 4'h1, 1'b0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0);
      check("mrmovq_reg14", d_regs[14], 64'hFFFF_FFFF_FFFF_FFFF);
      check("mrmovq_reg1", d_regs[1], 64'h0);
      apply(1'b1, 1'b1, 4'hA, 4'h6, 4'h7, 1'b0, 64'h1F8, 64'h5, 2'd0);
      check("pushq_reg4", d_regs[4], 64'h1F8);
      apply(1'b1, 1'b1, 4'h8, 4'h6, 4'h7, 1'b0, 64'h1F0, 64'h5, 2'd0);
      apply(1'b1, 1'b1, 4'h9, 4'h6, 4'h7, 1'b0, 64'h1F8, 64'h5, 2'd0);
      apply(1'b1, 1'b1, 4'h4, 4'h6, 4'h7, 1'b0, 64'h99, 64'h98, 2'd0);
      apply(1'b1, 1'b1, 4'h7, 4'h6, 4'h7, 1'b0, 64'h99, 64'h98, 2'd0);
      apply(1'b1, 1'b1, 4'h3, 4'hF, 4'hF, 1'b0, 64'hDEAD, 64'h0, 2'd0);
      check("rspec_none_reg14", d_regs[14], 64'hFFFF_FFFF_FFFF_FFFF);

      apply(1'b1, 1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h9, 64'h0, 2'd1);
      check("halt_reg1", d_regs[1], 64'h0);
      check("halt_flag", 64'(halted), 64'h1);
      apply(1'b1, 1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h9, 64'h0, 2'd0);
      check("halted_nowrite", d_regs[1], 64'h0);
      check("halt_sticky", 64'(halted), 64'h1);
      apply(1'b0, 1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h9, 64'h0, 2'd0);
      check("rst_halted", 64'(halted), 64'h0);
      check("rst_reg4", d_regs[4], 64'h200);
      check("rst_reg3", d_regs[3], 64'h0);

      apply(1'b1, 1'b1, 4'h3, 4'hF, 4'h6, 1'b0, 64'h66, 64'h0, 2'd2);
      check("adr_halt", 64'(halted), 64'h1);
      check("adr_reg6", d_regs[6], 64'h0);
      apply(1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 2'd0);

      apply(1'b1, 1'b0, 4'h3, 4'hF, 4'h5, 1'b0, 64'hFF, 64'h0, 2'd0);
      check("noen_reg5", d_regs[5], 64'h0);
      apply(1'b1, 1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'h77, 64'h0, 2'd0);
      check("en_reg5", d_regs[5], 64'h77);
      apply(1'b0, 1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'hFF, 64'h0, 2'd0);
      check("rst_over_write_reg5", d_regs[5], 64'h0);
      apply(1'b1, 1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 2'd0);

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
Y86-64 SEQ write-back stage plus the architectural register file.
- Holds registers %rax..%r14 (IDs 0..14); ID 15 (0xF) means "no register".
- Computes the write destinations dstE/dstM from the current instruction and commits valE/valM on the clock edge.
- Drives reg0..reg14 straight into the decode stage's register inputs, so decode reads what was committed at the previous edge.
- Also owns the sticky processor-halt flag.

Parameters:
- REG_W, 64: register/data width.
- NREGS, 15: number of architectural registers. Fixed at 15; kept as a parameter for readability only.
- RSP_INIT, 64'h0000_0000_0000_0200: reset value of reg4 (%rsp).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- wb_en  in  1  commit strobe: 1 = the current instruction retires this cycle.
- icode  in  4  instruction code.
- rA  in  4  register specifier A.
- rB  in  4  register specifier B.
- cnd  in  1  condition result from execute (used by cmovXX only).
- valE  in  REG_W  ALU result.
- valM  in  REG_W  memory read data.
- stat  in  2  instruction status: 0=AOK, 1=HLT, 2=ADR, 3=INS.
- reg0..reg14  out  REG_W each  registered architectural state.
- dstE  out  4  combinational E-port destination (0xF = none).
- dstM  out  4  combinational M-port destination (0xF = none).
- halted  out  1  sticky halt flag.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - all regs = 0, except reg4 = RSP_INIT;
  - halted = 0;
  - reset overrides wb_en and any write in the same cycle, including when asserted mid-program.
- dstE decode (combinational, from icode/rA/rB/cnd):
  - cmovXX (2): dstE = cnd ? rB : F;
  - irmovq (3) and OPq (6): dstE = rB;
  - pushq (A), popq (B), call (8), ret (9): dstE = 4;
  - all other icodes: dstE = F.
- dstM decode (combinational):
  - mrmovq (5) and popq (B): dstM = rA;
  - all other icodes: dstM = F.
- Commit condition: commit = wb_en & ~halted & (stat==AOK).
  - When commit=1: at the rising edge, reg[dstE] <= valE if dstE != F, and reg[dstM] <= valM if dstM != F.
  - When commit=0: no register changes.
- Same-destination conflict: if dstE == dstM and both != F (e.g. popq %rsp), the M port wins and reg = valM.
- Specifier 0xF on either port is a no-op. An out-of-range index never aliases onto a real register.
- Halt:
  - at the edge where wb_en=1 and stat != AOK, halted <= 1 and no write occurs;
  - halted stays 1 until reset;
  - wb_en has no effect while halted=1.
- icode 0 (halt) arrives with stat=HLT from fetch. This block does not decode icode 0 itself.
- Latency:
  - a write is visible on regN one cycle after the committing edge;
  - there is no read-during-write bypass; decode sees the old value in the same cycle.
- dstE/dstM are purely combinational, with no reset dependency. They are exported for the later pipeline hazard unit.
- Width: valE/valM are written unmodified at full width, with no extension or truncation.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: I_HALT=0, I_NOP=1, I_CMOV=2, I_IRMOV=3, I_RMMOV=4, I_MRMOV=5, I_OPQ=6, I_JXX=7, I_CALL=8, I_RET=9, I_PUSH=A, I_POP=B;
  - register IDs: R_RSP=4, R_NONE=F;
  - stat codes: S_AOK, S_HLT, S_ADR, S_INS.
- One natural sub-module: wb_dst_sel, the combinational dstE/dstM selector. It is reusable by the PIPE hazard logic.
- The register array and halt flag stay in the top module.

Test Plan:
1. Reset release -> reg0..reg14 = 0 except reg4 = 0x200; halted=0; dstE = dstM = F with icode=1.
2. irmovq: icode=3, rB=2, valE=0x1234, wb_en=1 -> reg2=0x1234 next cycle; all others unchanged. Then OPq: icode=6, rB=2, valE=0x55 -> reg2=0x55.
3. cmovXX: icode=2, rB=3, valE=7. With cnd=0 -> reg3 unchanged and dstE=F. With cnd=1 -> reg3=7.
4. popq %rsp: icode=B, rA=4, valE=0x208, valM=0xABCD -> reg4=0xABCD (M wins). popq %rbx (rA=3), same values -> reg3=0xABCD and reg4=0x208.
5. Halt: icode=3, rB=1, valE=9, stat=HLT, wb_en=1 -> reg1 unchanged, halted=1. Following AOK irmovq -> still no write. Assert rst_n=0 -> halted=0 and registers reinitialised.
6. wb_en=0 with icode=3, rB=5, valE=0xFF -> reg5 unchanged. Reset asserted in the same cycle as a valid write to reg5 -> reg5=0.
